// File: rtl/raggedstone_aer_to_spinn_pkt_gen.sv
// AER event receiver: synchronises a 4-phase req/ack sensor handshake and emits
// one SpiNNaker short multicast packet (or a counted drop) per event.
package raggedstone_aer_to_spinn_pkt_gen_pkg;
   localparam int unsigned VKEY_BITS = 32;
   localparam int unsigned PKT_BITS  = 72;

   typedef struct packed {
      logic [PKT_BITS-VKEY_BITS-9:0] rsvd;
      logic [VKEY_BITS-1:0]          key;
      logic [6:0]                    ctrl;
      logic                          parity;
   } pkt_t;
endpackage

module raggedstone_aer_to_spinn_pkt_gen
   import raggedstone_aer_to_spinn_pkt_gen_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned CNT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] iaer_addr,
   input  logic                 iaer_req,
   output logic                 iaer_ack,
   input  logic [VKEY_BITS-1:0] vkey,
   input  logic                 go,
   output logic [PKT_BITS-1:0]  opkt_data,
   output logic                 opkt_vld,
   input  logic                 opkt_rdy,
   output logic [CNT_BITS-1:0]  drop_cnt
);

   typedef enum logic [1:0] {IDLE, SEND, DROP, ACK} state_t;

   state_t               state_q, state_d;
   logic                 req_meta_q, req_s_q;
   pkt_t                 pkt_q, pkt_d;
   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic                 vld_q, vld_d;
   logic                 ack_q, ack_d;
   logic [VKEY_BITS-1:0] key_c;

   // two-flop synchroniser for the asynchronous request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_meta_q <= 1'b0;
         req_s_q    <= 1'b0;
      end else begin
         req_meta_q <= iaer_req;
         req_s_q    <= req_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pkt_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         ack_q   <= ack_d;
      end
   end

   // address is bundled data: only looked at once req_s confirms it is stable
   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      cnt_d   = cnt_q;
      key_c   = vkey;
      key_c[ADDR_BITS-1:0] = iaer_addr;

      case (state_q)
         IDLE: begin
            if (req_s_q) begin
               if (go) begin
                  pkt_d.rsvd   = '0;
                  pkt_d.key    = key_c;
                  pkt_d.ctrl   = 7'(0);
                  pkt_d.parity = ~^key_c;
                  state_d      = SEND;
               end else begin
                  state_d = DROP;
               end
            end
         end
         SEND: begin
            if (opkt_rdy) state_d = ACK;
         end
         DROP: begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
            state_d = ACK;
         end
         ACK: begin
            if (!req_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      vld_d = (state_d == SEND);
      ack_d = (state_d == ACK);
   end

   assign opkt_data = pkt_q;
   assign opkt_vld  = vld_q;
   assign iaer_ack  = ack_q;
   assign drop_cnt  = cnt_q;

endmodule
